// File: rtl/serial_window_buffer_if.sv
// Handshake and data bundle between the serial sample source, the window buffer and the SAD array.
interface serial_window_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 80
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   slide_mode;
  logic                   out_valid;
  logic                   out_ack;
  logic [DEPTH*WIDTH-1:0] out_data;
  logic [CNT_W-1:0]       fill_count;
  logic                   overflow;

  modport master (
    output in_valid, in_data, slide_mode, out_ack,
    input  in_ready, out_valid, out_data, fill_count, overflow
  );

  modport slave (
    input  in_valid, in_data, slide_mode, out_ack,
    output in_ready, out_valid, out_data, fill_count, overflow
  );
endinterface

// File: rtl/serial_window_buffer.sv
// Serial-in / parallel-out window buffer with block and slide release for the SAD datapath.
// Define SWB_ZERO_MASK_EN to force out_data to zero whenever no window is being presented.
module serial_window_buffer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 80,
  parameter int STRIDE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_window_buffer_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                       r_state, w_next_state;
  logic [DEPTH-1:0][WIDTH-1:0]  r_slots;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_ovf;

  logic w_in_ready, w_accept, w_release, w_last;

  assign w_in_ready = (r_state == FILL);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_release  = bus.out_ack & (r_state == FULL);
  assign w_last     = (r_cnt == CNT_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL: if (w_accept && w_last) w_next_state = FULL;
      FULL: if (bus.out_ack)        w_next_state = FILL;
      default:                      w_next_state = FILL;
    endcase
  end

  // Slide release with STRIDE==DEPTH collapses to a block release: count goes to 0, nothing shifts.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= r_cnt + CNT_W'(1);
    else if (w_release)
      r_cnt <= bus.slide_mode ? CNT_W'(DEPTH - STRIDE) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slots <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < DEPTH; i++)
        if (r_cnt == CNT_W'(i)) r_slots[i] <= bus.in_data;
    end else if (w_release && bus.slide_mode) begin
      for (int i = 0; i < DEPTH - STRIDE; i++)
        r_slots[i] <= r_slots[i + STRIDE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else     r_ovf <= r_ovf | (bus.in_valid & ~w_in_ready);
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == FULL);
  assign bus.fill_count = r_cnt;
  assign bus.overflow   = r_ovf;

`ifdef SWB_ZERO_MASK_EN
  assign bus.out_data = (r_state == FULL) ? r_slots : '0;
`else
  assign bus.out_data = r_slots;
`endif
endmodule

// File: tb/tb_serial_window_buffer.sv
// Randomized and directed bench for serial_window_buffer against a queue-based window model.
module tb_serial_window_buffer;
  localparam int W = 8;
  localparam int D = 80;
  localparam int S = 16;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_window_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  serial_window_buffer #(.WIDTH(W), .DEPTH(D), .STRIDE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: q is the current window (oldest first); mem is what the raw slot storage shows.
  logic [W-1:0] q[$];
  logic [W-1:0] mem[D];
  bit           m_full = 1'b0;
  bit           m_ovf  = 1'b0;

  function automatic logic [D*W-1:0] exp_data();
    logic [D*W-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) v[W*i +: W] = mem[i];
`ifdef SWB_ZERO_MASK_EN
    if (!m_full) v = '0;
`endif
    return v;
  endfunction

  function automatic logic [W-1:0] slice(input int i);
    return bus.out_data[W*i +: W];
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d, input logic ack,
                      input logic sm, input logic r);
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.out_ack    = ack;
    bus.slide_mode = sm;
    rst            = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      foreach (mem[i]) mem[i] = '0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
    end else if (!m_full) begin
      if (v) begin
        mem[q.size()] = d;
        q.push_back(d);
        if (q.size() == D) m_full = 1'b1;
      end
    end else begin
      if (v) m_ovf = 1'b1;
      if (ack) begin
        if (sm) begin
          for (int k = 0; k < S; k++) void'(q.pop_front());
          for (int k = 0; k < q.size(); k++) mem[k] = q[k];
        end else begin
          q.delete();
        end
        m_full = 1'b0;
      end
    end
    #1;
  endtask

  task automatic fill_seq(input int first, input int n);
    for (int i = 0; i < n; i++) step(1'b1, W'(first + i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (bus.fill_count !== '0) begin n_errors++; $display("FAIL reset_fill_count got %0d exp 0", bus.fill_count); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
    n_checks++; if (bus.out_data !== '0) begin n_errors++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
  endtask

  task automatic test_block_fill();
    fill_seq(1, D - 1);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL block_early_valid got %b exp 0", bus.out_valid); end
    fill_seq(D, 1);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL block_out_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL block_in_ready got %b exp 0", bus.in_ready); end
    n_checks++; if (slice(0) !== 8'd1) begin n_errors++; $display("FAIL block_slice0 got %0d exp 1", slice(0)); end
    n_checks++; if (slice(D-1) !== 8'd80) begin n_errors++; $display("FAIL block_slice79 got %0d exp 80", slice(D-1)); end
    n_checks++; if (bus.fill_count !== CW'(D)) begin n_errors++; $display("FAIL block_fill_count got %0d exp %0d", bus.fill_count, D); end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.fill_count !== '0) begin n_errors++; $display("FAIL block_ack_count got %0d exp 0", bus.fill_count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL block_ack_ready got %b exp 1", bus.in_ready); end
`ifdef SWB_ZERO_MASK_EN
    n_checks++; if (bus.out_data !== '0) begin n_errors++; $display("FAIL block_masked got %h exp 0", bus.out_data); end
`else
    n_checks++; if (slice(D-1) !== 8'd80) begin n_errors++; $display("FAIL block_stale_slot got %0d exp 80", slice(D-1)); end
`endif
  endtask

  task automatic test_slide();
    fill_seq(1, D);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (bus.fill_count !== CW'(D - S)) begin n_errors++; $display("FAIL slide_count got %0d exp %0d", bus.fill_count, D - S); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL slide_out_valid got %b exp 0", bus.out_valid); end
`ifdef SWB_ZERO_MASK_EN
    n_checks++; if (bus.out_data !== '0) begin n_errors++; $display("FAIL slide_masked got %h exp 0", bus.out_data); end
`else
    n_checks++; if (slice(0) !== 8'd17) begin n_errors++; $display("FAIL slide_slice0 got %0d exp 17", slice(0)); end
    n_checks++; if (slice(D-S-1) !== 8'd80) begin n_errors++; $display("FAIL slide_slice63 got %0d exp 80", slice(D-S-1)); end
`endif
    fill_seq(D + 1, S);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL slide_refill_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (slice(0) !== 8'd17) begin n_errors++; $display("FAIL slide_full_slice0 got %0d exp 17", slice(0)); end
    n_checks++; if (slice(D-S) !== 8'd81) begin n_errors++; $display("FAIL slide_slice64 got %0d exp 81", slice(D-S)); end
    n_checks++; if (slice(D-1) !== 8'd96) begin n_errors++; $display("FAIL slide_slice79 got %0d exp 96", slice(D-1)); end
    n_checks++; if (bus.out_data !== exp_data()) begin n_errors++; $display("FAIL slide_window got %h exp %h", bus.out_data, exp_data()); end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [D*W-1:0] held;
    for (int i = 0; i < D; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
    held = bus.out_data;
    n_checks++; if (held !== exp_data()) begin n_errors++; $display("FAIL bp_window got %h exp %h", held, exp_data()); end
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL bp_overflow got %b exp 1", bus.overflow); end
    n_checks++; if (bus.out_data !== exp_data()) begin n_errors++; $display("FAIL bp_data_held got %h exp %h", bus.out_data, exp_data()); end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL bp_sticky got %b exp 1", bus.overflow); end
    step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.fill_count !== CW'(1)) begin n_errors++; $display("FAIL bp_count got %0d exp 1", bus.fill_count); end
    fill_seq(2, D - 1);
    n_checks++; if (slice(0) !== 8'hAB) begin n_errors++; $display("FAIL bp_slot0 got %h exp ab", slice(0)); end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] first;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL rm_ovf_clear got %b exp 0", bus.overflow); end
    for (int i = 0; i < 40; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.fill_count !== '0) begin n_errors++; $display("FAIL rm_count got %0d exp 0", bus.fill_count); end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (bus.fill_count !== '0) begin n_errors++; $display("FAIL rm_stray_ack got %0d exp 0", bus.fill_count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL rm_stray_ready got %b exp 1", bus.in_ready); end
    first = W'($urandom);
    step(1'b1, first, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < D; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL rm_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (slice(0) !== first) begin n_errors++; $display("FAIL rm_slice0 got %h exp %h", slice(0), first); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(9) < 7), W'($urandom), ($urandom_range(9) < 3),
           1'($urandom), ($urandom_range(199) == 0));
      n_checks++;
      if (bus.out_valid !== m_full || bus.in_ready !== !m_full ||
          bus.fill_count !== CW'(q.size()) || bus.overflow !== m_ovf) begin
        n_errors++;
        $display("FAIL rand_ctrl cyc %0d got v%b r%b n%0d o%b exp v%b r%b n%0d o%b", c,
                 bus.out_valid, bus.in_ready, bus.fill_count, bus.overflow,
                 m_full, !m_full, q.size(), m_ovf);
      end
      n_checks++;
      if (bus.out_data !== exp_data()) begin
        n_errors++;
        $display("FAIL rand_data cyc %0d got %h exp %h", c, bus.out_data, exp_data());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ack = 1'b0; bus.slide_mode = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    test_reset();
    test_block_fill();
    test_slide();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
